// File: rtl/tt_pin_pipe_pkg.sv
// Shared definitions for the pin pipe block:
// output mode encodings and control-pin bit positions.
package tt_pin_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_DELAY = 2'b01,
    MODE_EDGE  = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  localparam int MODE_LSB = 0;
  localparam int MODE_W   = 2;
  localparam int TAP_LSB  = 2;
  localparam int CLR_BIT  = 7;

endpackage

// File: rtl/tt_pin_delay_line.sv
// Enabled shift-register chain with a selectable tap.
// The first two stages are exported for edge detection.
module tt_pin_delay_line #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int TAP_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [W-1:0]     d,
  input  logic [TAP_W-1:0] tap,
  output logic [W-1:0]     s0,
  output logic [W-1:0]     s1,
  output logic [W-1:0]     q
);

  logic [W-1:0] s [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        s[k] <= '0;
      end
    end else if (ena) begin
      s[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        s[k] <= s[k-1];
      end
    end
  end

  assign s0 = s[0];
  assign s1 = s[1];
  assign q  = s[tap];

endmodule

// File: rtl/tt_um_pin_pipe.sv
// Pin pipe top: registered controls, delay line, rising-edge
// sticky flags and a bit-0 edge counter, muxed onto uo_out.
module tt_um_pin_pipe
  import tt_pin_pipe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAP_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  mode_e            mode_q;
  mode_e            mode_prev;
  logic [TAP_W-1:0] tap_q;
  logic             clr_q;
  logic [7:0]       sticky;
  logic [7:0]       cnt;
  logic [7:0]       s0;
  logic [7:0]       s1;
  logic [7:0]       dly_q;
  logic [7:0]       rise;
  logic             clear;

  wire unused_uio = &{1'b0, uio_in[CLR_BIT-1:TAP_LSB+TAP_W]};

  tt_pin_delay_line #(
    .DEPTH (DEPTH),
    .W     (8),
    .TAP_W (TAP_W)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (ui_in),
    .tap   (tap_q),
    .s0    (s0),
    .s1    (s1),
    .q     (dly_q)
  );

  assign rise  = s0 & ~s1;
  // A mode switch clears exactly like the clear pin.
  assign clear = clr_q | (mode_q != mode_prev);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= MODE_PASS;
      mode_prev <= MODE_PASS;
      tap_q     <= '0;
      clr_q     <= 1'b0;
      sticky    <= '0;
      cnt       <= '0;
    end else if (ena) begin
      mode_q    <= mode_e'(uio_in[MODE_LSB +: MODE_W]);
      mode_prev <= mode_q;
      tap_q     <= uio_in[TAP_LSB +: TAP_W];
      clr_q     <= uio_in[CLR_BIT];
      if (clear) begin
        sticky <= '0;
        cnt    <= '0;
      end else begin
        sticky <= sticky | rise;
        cnt    <= cnt + 8'(rise[0]);
      end
    end
  end

  always_comb begin
    uo_out = '0;
    unique case (mode_q)
      MODE_PASS:  uo_out = s0;
      MODE_DELAY: uo_out = dly_q;
      MODE_EDGE:  uo_out = sticky;
      MODE_COUNT: uo_out = cnt;
      default:    uo_out = '0;
    endcase
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_pin_pipe.sv
// Scoreboard bench for tt_um_pin_pipe: timed expectations
// are queued at drive time and compared at the due cycle.
module tb_tt_um_pin_pipe;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      tag;
  } sb_t;

  sb_t sbq[$];

  tt_um_pin_pipe #(.DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic push(input int k,
                      input logic [7:0] exp,
                      input string tag);
    sb_t e;
    e.due = cyc + k;
    e.exp = exp;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        chk(sbq[i].tag, uo_out, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ctl(input logic [1:0] m,
                         input logic [2:0] t,
                         input logic c);
    uio_in = {c, 2'b00, t, m};
  endtask

  task automatic pulse();
    ui_in = 8'h01;
    tick(1);
    ui_in = 8'h00;
    tick(1);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'h00;
    tick(1);

    for (int m = 0; m < 4; m++) begin
      set_ctl(2'(m), 3'd0, 1'b0);
      tick(1);
      chk("rst_mode", uo_out, 8'h00);
    end
    ui_in = 8'h00;
    set_ctl(2'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst", uo_out, 8'h00);
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);

    // PASS latency
    tick(2);
    ui_in = 8'hA5;
    chk("pass_pre", uo_out, 8'h00);
    push(1, 8'hA5, "pass");
    tick(3);

    // DELAY tap 5 and tap 7
    set_ctl(2'd1, 3'd5, 1'b0);
    ui_in = 8'h00;
    tick(9);
    ui_in = 8'hA5;
    push(5, 8'h00, "dly5_pre");
    push(6, 8'hA5, "dly5");
    tick(8);
    set_ctl(2'd1, 3'd7, 1'b0);
    ui_in = 8'h00;
    tick(10);
    ui_in = 8'h5A;
    push(7, 8'h00, "dly7_pre");
    push(8, 8'h5A, "dly7");
    tick(10);

    // EDGE sticky and clear
    set_ctl(2'd2, 3'd0, 1'b0);
    ui_in = 8'h00;
    tick(4);
    chk("edge_idle", uo_out, 8'h00);
    ui_in = 8'h81;
    push(1, 8'h00, "edge_pre");
    push(2, 8'h81, "edge_set");
    push(6, 8'h81, "edge_hold");
    tick(1);
    ui_in = 8'h00;
    tick(6);
    set_ctl(2'd2, 3'd0, 1'b1);
    push(1, 8'h81, "clr_pre");
    push(2, 8'h00, "clr_done");
    tick(1);
    set_ctl(2'd2, 3'd0, 1'b0);
    tick(3);

    // COUNT wrap
    set_ctl(2'd3, 3'd0, 1'b0);
    tick(4);
    chk("cnt_zero", uo_out, 8'h00);
    for (int i = 1; i <= 257; i++) begin
      pulse();
      if (i == 255) chk("cnt_255", uo_out, 8'hFF);
      if (i == 256) chk("cnt_256", uo_out, 8'h00);
    end
    chk("cnt_wrap", uo_out, 8'h01);

    // Clear versus edge race
    set_ctl(2'd3, 3'd0, 1'b1);
    tick(1);
    set_ctl(2'd3, 3'd0, 1'b0);
    tick(3);
    chk("clr_cnt", uo_out, 8'h00);
    ui_in = 8'h01;
    set_ctl(2'd3, 3'd0, 1'b1);
    tick(1);
    set_ctl(2'd3, 3'd0, 1'b0);
    tick(3);
    ui_in = 8'h00;
    tick(2);
    chk("race", uo_out, 8'h00);
    repeat (3) pulse();
    chk("cnt_3", uo_out, 8'h03);
    set_ctl(2'd2, 3'd0, 1'b0);
    tick(3);
    set_ctl(2'd3, 3'd0, 1'b0);
    tick(3);
    chk("mode_sw", uo_out, 8'h00);

    // ena freeze in COUNT
    repeat (2) pulse();
    chk("cnt_2", uo_out, 8'h02);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ui_in = i[0] ? 8'h00 : 8'hFF;
      tick(1);
      chk("frz_cnt", uo_out, 8'h02);
    end
    ena   = 1'b1;
    ui_in = 8'h01;
    push(1, 8'h02, "resume_pre");
    push(2, 8'h03, "resume");
    tick(3);
    ui_in = 8'h00;
    tick(2);

    // ena freeze in DELAY, tap 3
    set_ctl(2'd1, 3'd3, 1'b0);
    tick(6);
    ui_in = 8'hC3;
    tick(1);
    ui_in = 8'h00;
    tick(1);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ui_in = i[0] ? 8'h00 : 8'h3C;
      tick(1);
      chk("frz_dly", uo_out, 8'h00);
    end
    ena   = 1'b1;
    ui_in = 8'h00;
    push(1, 8'h00, "frz_dly_pre");
    push(2, 8'hC3, "frz_dly_out");
    tick(4);

    // Reset mid-delay flushes the chain
    set_ctl(2'd1, 3'd7, 1'b0);
    ui_in = 8'h77;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    ui_in = 8'h00;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("rst_flush", uo_out, 8'h00);
    end

    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick(1);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL sb_timeout: got %0d pending expected 0",
               sbq.size());
    end
    chk("uio_out_end", uio_out, 8'h00);
    chk("uio_oe_end", uio_oe, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_pin_pipe.md
TT_UM_PIN_PIPE -- requirements
Module: tt_um_pin_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 8: delay-line stages; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter TAP_W, default $clog2(DEPTH): tap-select width, derived and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: when low, all state holds.
REQ-006 SHALL have port ui_in, input, 8 bits: data inputs.
REQ-007 SHALL have port uo_out, output, 8 bits: data outputs.
REQ-008 SHALL have port uio_in, input, 8 bits: control, as follows.
- [1:0] mode.
- [2+TAP_W-1:2] delay tap.
- [7] clear.
- All remaining bits unused.
REQ-009 SHALL have port uio_out, output, 8 bits: constant 0.
REQ-010 SHALL have port uio_oe, output, 8 bits: constant 0 (all uio pins are inputs).

Function
REQ-011 SHALL shift ui_in into an 8-bit-wide, DEPTH-stage register chain s[0..DEPTH-1] every enabled cycle, with s[0] <= ui_in and s[k] <= s[k-1].
REQ-012 SHALL register mode, tap and clear into mode_q, tap_q and clr_q every enabled cycle.
REQ-013 SHALL drive uo_out as a combinational mux of registered state selected by mode_q; no input reaches uo_out combinationally.
REQ-014 PASS (mode_q=00) SHALL output uo_out = s[0], i.e. ui_in with 1-cycle latency.
REQ-015 DELAY (mode_q=01) SHALL output uo_out = s[tap_q], i.e. ui_in with latency tap_q+1 cycles.
- tap_q = 0 is identical to PASS.
- tap_q = DEPTH-1 gives the maximum latency, DEPTH cycles.
REQ-016 Rising edge on bit i SHALL be defined as s[0][i] & ~s[1][i].
REQ-017 EDGE (mode_q=10) SHALL output uo_out = sticky[7:0].
- sticky[i] sets the cycle after a rising edge on bit i.
- sticky[i] remains set until cleared.
REQ-018 COUNT (mode_q=11) SHALL output uo_out = cnt[7:0], an 8-bit count of rising edges on bit 0.
REQ-019 cnt SHALL wrap from 255 to 0 with no saturation and no flag.
REQ-020 clr_q high SHALL zero sticky and cnt on the next edge.
- clr_q takes priority over a simultaneous rising edge; that edge is dropped.
REQ-021 A change of mode_q (mode_q != its previous value) SHALL act as a clear identical to clr_q.
REQ-022 Mode change SHALL NOT flush the delay chain; DELAY output is valid immediately after switching.
REQ-023 ena low SHALL freeze every register, including the chain, sticky, cnt and mode_q; uo_out holds its last value; edges are not detected.
REQ-024 sticky and cnt SHALL update in all modes, subject to REQ-021.

Reset
REQ-025 While rst_n is low at a clock edge, the block SHALL zero s[*], sticky, cnt, mode_q, tap_q, clr_q and the previous-mode register, regardless of ena.
REQ-026 uo_out SHALL be 0 in the cycle following reset; uio_out and uio_oe SHALL be 0 always.
REQ-027 Reset asserted mid-count or mid-delay SHALL discard all in-flight data; the first post-reset edge detection SHALL compare against zeroed s[1].

Structure
REQ-028 Mode encodings (PASS, DELAY, EDGE, COUNT) and control bit positions SHALL live in shared package tt_pin_pipe_pkg.
REQ-029 The delay chain SHALL be a sub-module tt_pin_delay_line, parametrised by DEPTH and width, with tap mux output.
REQ-030 Edge, sticky and counter logic SHALL remain in the top module.

Verification
REQ-031 Reset: hold rst_n=0 with ui_in=8'hFF for 3 cycles -> uo_out=8'h00 in all modes.
REQ-032 PASS and DELAY:
- mode=00, ui_in steps 8'h00->8'hA5 -> uo_out=8'hA5 exactly 1 cycle later.
- mode=01, tap=5 -> uo_out=8'hA5 exactly 6 cycles after the step.
REQ-033 EDGE:
- mode=10, pulse ui_in=8'h81 for 1 cycle -> uo_out=8'h81 and stays after ui_in returns to 0.
- clear pulse (uio_in[7]) -> uo_out=8'h00 two cycles later.
REQ-034 COUNT wrap: mode=11, 257 rising edges on ui_in[0] -> uo_out=8'h01.
REQ-035 Clear-vs-edge race: clear and rising edge in the same registered cycle -> count unchanged at 0; switching mode 11->10->11 zeroes cnt.
REQ-036 ena freeze: ena=0 for 10 cycles with ui_in toggling in COUNT and DELAY modes -> uo_out constant; counting resumes exactly when ena=1.
